// File: rtl/pixel_ctrl_pkg.sv
// Shared types, default dwell lengths and Gray helpers for the pixel array sequencer.
// Gray helpers are used when PIXCTRL_GRAY_EN is defined.
package pixel_ctrl_pkg;

   localparam int CNT_W        = 8;
   localparam int C_ERASE_DEF  = 5;
   localparam int C_EXPOSE_DEF = 255;
   localparam int C_READ_DEF   = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ERASE,
      S_EXPOSE,
      S_CONVERT,
      S_READ12,
      S_READ34
   } state_t;

   function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [CNT_W-1:0] gray2bin(input logic [CNT_W-1:0] g);
      logic [CNT_W-1:0] b;
      b[CNT_W-1] = g[CNT_W-1];
      for (int i = CNT_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// Ramp count driven onto the DATA buses during conversion; output is registered.
// PIXCTRL_GRAY_EN selects Gray-coded output instead of plain binary.
module pixel_conv_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             enable,
   input  logic             clear,
   output logic [CNT_W-1:0] data_out
);
`ifdef PIXCTRL_GRAY_EN
   import pixel_ctrl_pkg::bin2gray;
`endif

   logic [CNT_W-1:0] bin;
   logic [CNT_W-1:0] bin_nxt;
   logic [CNT_W-1:0] enc_nxt;

   assign bin_nxt = bin + CNT_W'(1);

`ifdef PIXCTRL_GRAY_EN
   assign enc_nxt = bin2gray(bin_nxt);
`else
   assign enc_nxt = bin_nxt;
`endif

   // Encoded value is registered alongside the count so the bus never sees a decode glitch.
   always_ff @(posedge clk) begin
      if (clear) begin
         bin      <= '0;
         data_out <= '0;
      end else if (enable) begin
         bin      <= bin_nxt;
         data_out <= enc_nxt;
      end
   end

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer for the 2x2 pixel array: erase, expose, ramp convert, read two pixel pairs.
// PIXCTRL_GRAY_EN: Gray ramp on the bus, captured codes decoded back to binary.
module pixel_array_ctrl #(
   parameter int C_ERASE  = pixel_ctrl_pkg::C_ERASE_DEF,
   parameter int C_EXPOSE = pixel_ctrl_pkg::C_EXPOSE_DEF,
   parameter int C_READ   = pixel_ctrl_pkg::C_READ_DEF,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic             ERASE,
   output logic             EXPOSE,
   output logic             CONVERT,
   output logic             READ12,
   output logic             READ34,
   output logic [CNT_W-1:0] data_out,
   output logic             data_oe,
   input  logic [CNT_W-1:0] data1,
   input  logic [CNT_W-1:0] data2,
   input  logic [CNT_W-1:0] data3,
   input  logic [CNT_W-1:0] data4,
   output logic [CNT_W-1:0] pix_a,
   output logic [CNT_W-1:0] pix_b,
   output logic             pix_pair,
   output logic             pix_valid,
   output logic             busy,
   output logic             frame_done
);
   import pixel_ctrl_pkg::state_t;
   import pixel_ctrl_pkg::S_IDLE;
   import pixel_ctrl_pkg::S_ERASE;
   import pixel_ctrl_pkg::S_EXPOSE;
   import pixel_ctrl_pkg::S_CONVERT;
   import pixel_ctrl_pkg::S_READ12;
   import pixel_ctrl_pkg::S_READ34;
`ifdef PIXCTRL_GRAY_EN
   import pixel_ctrl_pkg::gray2bin;
`endif

   localparam logic [15:0] D_ERASE  = 16'(C_ERASE - 1);
   localparam logic [15:0] D_EXPOSE = 16'(C_EXPOSE - 1);
   localparam logic [15:0] D_CONV   = 16'((1 << CNT_W) - 1);
   localparam logic [15:0] D_READ   = 16'(C_READ - 1);

   state_t           state;
   logic [15:0]      dwell;
   logic [CNT_W-1:0] cap1, cap2, cap3, cap4;

`ifdef PIXCTRL_GRAY_EN
   assign cap1 = gray2bin(data1);
   assign cap2 = gray2bin(data2);
   assign cap3 = gray2bin(data3);
   assign cap4 = gray2bin(data4);
`else
   assign cap1 = data1;
   assign cap2 = data2;
   assign cap3 = data3;
   assign cap4 = data4;
`endif

   // Bus drive tracks the CONVERT strobe flop exactly, so both drop on the same edge.
   assign data_oe = CONVERT;

   pixel_conv_counter #(.CNT_W(CNT_W)) u_ramp (
      .clk      (clk),
      .enable   (CONVERT),
      .clear    (reset | ~CONVERT),
      .data_out (data_out)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         dwell      <= '0;
         ERASE      <= 1'b0;
         EXPOSE     <= 1'b0;
         CONVERT    <= 1'b0;
         READ12     <= 1'b0;
         READ34     <= 1'b0;
         busy       <= 1'b0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         pix_pair   <= 1'b0;
         pix_a      <= '0;
         pix_b      <= '0;
      end else begin
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (state != S_IDLE && dwell != 16'd0) begin
            dwell <= dwell - 16'd1;
         end
         case (state)
            S_IDLE: if (start) begin
               state <= S_ERASE;
               dwell <= D_ERASE;
               ERASE <= 1'b1;
               busy  <= 1'b1;
            end
            S_ERASE: if (dwell == 16'd0) begin
               state  <= S_EXPOSE;
               dwell  <= D_EXPOSE;
               ERASE  <= 1'b0;
               EXPOSE <= 1'b1;
            end
            S_EXPOSE: if (dwell == 16'd0) begin
               state   <= S_CONVERT;
               dwell   <= D_CONV;
               EXPOSE  <= 1'b0;
               CONVERT <= 1'b1;
            end
            S_CONVERT: if (dwell == 16'd0) begin
               state   <= S_READ12;
               dwell   <= D_READ;
               CONVERT <= 1'b0;
               READ12  <= 1'b1;
            end
            S_READ12: if (dwell == 16'd0) begin
               state     <= S_READ34;
               dwell     <= D_READ;
               READ12    <= 1'b0;
               READ34    <= 1'b1;
               pix_a     <= cap1;
               pix_b     <= cap2;
               pix_pair  <= 1'b0;
               pix_valid <= 1'b1;
            end
            S_READ34: if (dwell == 16'd0) begin
               state      <= S_IDLE;
               READ34     <= 1'b0;
               busy       <= 1'b0;
               pix_a      <= cap3;
               pix_b      <= cap4;
               pix_pair   <= 1'b1;
               pix_valid  <= 1'b1;
               frame_done <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/pixel_array_ctrl.md
# pixel_array_ctrl

Frame sequencer for the 2x2 pixel array. Drives the array's ERASE, EXPOSE, READ12 and READ34 strobes and a CONVERT strobe to the ramp generator. During conversion it drives an 8-bit count onto the shared DATA buses, where the pixels latch it. During readout it releases the buses, captures the latched pixel codes and presents them as two pixel pairs. It sits between the top-level camera control and the pixel array instance.

## Interface
Parameters:
- `C_ERASE`, 5: cycles ERASE is held high.
- `C_EXPOSE`, 255: cycles EXPOSE is held high; legal range 1..65535.
- `C_READ`, 5: cycles each READ strobe is held high before capture; minimum 2.
- `CNT_W`, 8: conversion counter and DATA width.

Ports:
- `clk` in 1: single clock; every register is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: level; begins one frame when sampled high in IDLE.
- `ERASE`, `EXPOSE`, `CONVERT`, `READ12`, `READ34` out 1 each: array strobes, registered.
- `data_out` out CNT_W: conversion count driven toward DATA1..4.
- `data_oe` out 1: tristate enable for `data_out`; high only in CONVERT.
- `data1`..`data4` in CNT_W each: DATA bus values as seen by the controller.
- `pix_a`, `pix_b` out CNT_W: captured codes; DATA1/DATA2 for pair 0, DATA3/DATA4 for pair 1.
- `pix_pair` out 1: 0 = pixels 1/2, 1 = pixels 3/4.
- `pix_valid` out 1: one-cycle pulse when `pix_a`/`pix_b`/`pix_pair` are valid.
- `busy` out 1: high in every state except IDLE.
- `frame_done` out 1: one-cycle pulse after the READ34 capture.

## Operation
- FSM states: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ12 -> READ34 -> IDLE.
- Each state owns one down-counter, `dwell`, 16 bits wide. On state entry it loads N-1, and the state exits on the cycle `dwell` == 0.
- State lengths:
  - ERASE: `C_ERASE` cycles.
  - EXPOSE: `C_EXPOSE` cycles.
  - CONVERT: exactly 2^CNT_W cycles.
  - READ12 and READ34: `C_READ` cycles each.
- Each strobe is high exactly while its state is active. At most one strobe is high in any cycle.
- CONVERT:
  - `data_oe` = 1.
  - `data_out` counts 0, 1, ..., 2^CNT_W-1, one step per cycle, with no wrap inside the state.
  - On exit, `data_oe` falls in the same cycle as CONVERT.
- READ12/READ34:
  - `data_oe` = 0.
  - On the last cycle of the state, `data1`/`data2` (READ12) or `data3`/`data4` (READ34) are registered into `pix_a`/`pix_b`.
  - `pix_valid` pulses in the following cycle, with `pix_pair` = 0 or 1 respectively.
- `frame_done` pulses in the same cycle as the pair-1 `pix_valid`, which is the first IDLE cycle.
- `start` is ignored while `busy` is high. If `start` is still high in IDLE after `frame_done`, the next frame begins: IDLE is occupied for one cycle between frames.
- `pix_a`/`pix_b` hold their last captured value until the next capture.

## Timing
- Reset (synchronous, highest priority, legal in any state):
  - Next state is IDLE.
  - All strobes, `data_oe`, `busy`, `pix_valid` and `frame_done` go to 0.
  - `data_out`, `pix_a`, `pix_b` and `pix_pair` go to 0.
  - A partial frame is abandoned and emits no `pix_valid`.
- `start` is sampled high in IDLE at edge k. ERASE and `busy` are high from edge k+1.
- Frame length from the first ERASE cycle to `frame_done`: `C_ERASE` + `C_EXPOSE` + 2^CNT_W + 2·`C_READ` + 1 cycles.
- With defaults that is 5+255+256+10+1 = 527 cycles.
- `data_out` is registered and changes on the same edge as the CONVERT transitions. The first CONVERT cycle shows 0.
- The READ strobe stays high during its capture cycle. Sampling at `C_READ`-1 cycles gives the bus keeper in the pixel settling time.

## Configuration
- `PIXCTRL_GRAY_EN` defined:
  - `data_out` during CONVERT is the Gray code of the binary count, `bin ^ (bin >> 1)`.
  - Captured `pix_a`/`pix_b` are converted from Gray back to binary before registering.
  - Latency is unchanged: the conversion is combinational ahead of the capture flop.
- Undefined: `data_out` is plain binary and captures are stored raw.

## Structure
- Shared package `pixel_ctrl_pkg`:
  - `state_t` enum: IDLE, ERASE, EXPOSE, CONVERT, READ12, READ34.
  - Default dwell constants.
  - `gray2bin`/`bin2gray` functions, parameterised by width through a `CNT_W` localparam.
- Sub-module `pixel_conv_counter`:
  - Ports: enable, clear, `data_out`.
  - Owns the 2^CNT_W ramp count and its optional Gray encoding.
- The FSM and capture registers live in `pixel_array_ctrl`.

## Test plan
- Reset, then `start`=1 for 1 cycle with defaults -> ERASE high for 5 cycles, EXPOSE for 255, CONVERT for 256, READ12 for 5, READ34 for 5. `frame_done` arrives at cycle 527, and no two strobes are ever high together.
- During CONVERT, check `data_out` each cycle -> values 0..255 in order, with `data_oe`=1 only in those 256 cycles.
- Behavioural pixel model latches `data_out` when a ramp comparator trips, with codes 17, 200, 0, 255 -> `pix_valid` with pair 0 carrying 17/200, then pair 1 carrying 0/255.
- `reset` asserted at cycle 300 (mid-CONVERT) -> next cycle all outputs 0 and state IDLE; no `pix_valid` or `frame_done` for that frame.
- `start` held high continuously -> back-to-back frames with exactly one idle cycle between `frame_done` and the next ERASE; a `start` pulse during EXPOSE is ignored.
- Build with `PIXCTRL_GRAY_EN`, where the pixel model latches when the count reaches binary 128 -> bus shows Gray 0xC0 (`8'hC0`) at that cycle and `pix_a` reads 128.
